// File: rtl/blvds_sim_pkg.sv
// Shared types and helpers for the BLVDS frame-init scheduler.
// Holds the mode/state enums, the default sample tag and the minimum-period rule.
package blvds_sim_pkg;

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_BURST    = 2'd2
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [5:0] TAG_DEF = 6'b110011;

    // Shortest period that still lets every channel offset occur once.
    function automatic int unsigned pmin(input int unsigned ch_num, input int unsigned stagger);
        return (ch_num - 1) * stagger + 1;
    endfunction

endpackage

// File: rtl/blvds_ch_strobe.sv
// One frame-sender channel: offset match, busy gating, registered init strobe
// and a sticky overrun flag for strobes dropped on a busy sender.
module blvds_ch_strobe #(
    parameter int CNT_W  = 26,
    parameter int OFFSET = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             mask_i,
    input  logic             busy_i,
    input  logic             clr_ovr_i,
    output logic             init_o,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] OFS = CNT_W'(OFFSET);

    logic hit;
    logic init_d, init_q;
    logic ovr_d, ovr_q;

    always_comb begin
        hit    = run_i && (cnt_i == OFS) && mask_i;
        init_d = hit && !busy_i;
        ovr_d  = ovr_q;
        // A drop in the same cycle as a clear request keeps the flag set.
        if (hit && busy_i) begin
            ovr_d = 1'b1;
        end else if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            init_q <= init_d;
            ovr_q  <= ovr_d;
        end
    end

    assign init_o    = init_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/blvds_frame_sched.sv
// Frame-init scheduler: periodic / one-shot / burst FSM with a shared period
// counter, frame counter and tagged sample word driving per-channel strobes.
module blvds_frame_sched
    import blvds_sim_pkg::*;
#(
    parameter int                CH_NUM     = 4,
    parameter int                CNT_W      = 26,
    parameter int                STAGGER    = 16,
    parameter int                TAG_W      = 6,
    parameter logic [TAG_W-1:0]  TAG        = TAG_W'(TAG_DEF),
    parameter logic [CNT_W-1:0]  PERIOD_DEF = CNT_W'(50000000)
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic                   iENA,
    input  logic [1:0]             iMODE,
    input  logic                   iSTART,
    input  logic [CNT_W-1:0]       iPERIOD,
    input  logic [7:0]             iBURST_LEN,
    input  logic [CH_NUM-1:0]      iCH_MASK,
    input  logic [CH_NUM-1:0]      iBUSY,
    input  logic                   iCLR_OVR,
    output logic [CH_NUM-1:0]      oINIT,
    output logic [TAG_W+CNT_W-1:0] oSAMPLE,
    output logic [15:0]            oFRAME_CNT,
    output logic                   oACTIVE,
    output logic [CH_NUM-1:0]      oOVERRUN,
    output state_e                 oDBG_STATE
);

    localparam logic [CNT_W-1:0] PMIN = CNT_W'(pmin(CH_NUM, STAGGER));

    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] r;
        r = (p == '0) ? PERIOD_DEF : p;
        if (r < PMIN) begin
            r = PMIN;
        end
        return r;
    endfunction

    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'd0:    r = MODE_PERIODIC;
            2'd2:    r = MODE_BURST;
            default: r = MODE_ONESHOT;
        endcase
        return r;
    endfunction

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync_d, rst_sync_q;
    logic       rst_n_sync;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_sync = rst_sync_q[1];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    state_e                   state_d, state_q;
    mode_e                    mode_d, mode_q;
    logic [CNT_W-1:0]         period_d, period_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;
    logic [7:0]               burst_d, burst_q;
    logic [15:0]              frame_d, frame_q;
    logic [TAG_W+CNT_W-1:0]   sample_d, sample_q;
    logic                     active_d, active_q;
    logic                     stop, wrap, run;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        burst_d  = burst_q;
        frame_d  = frame_q;
        sample_d = sample_q;
        stop     = 1'b0;
        run      = 1'b0;
        wrap     = (cnt_q == period_q - CNT_W'(1));

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if ((iMODE == 2'd0 && iENA) || (iMODE != 2'd0 && iSTART)) begin
                    state_d  = ST_RUN;
                    mode_d   = decode_mode(iMODE);
                    period_d = eff_period(iPERIOD);
                    burst_d  = (iBURST_LEN == 8'd0) ? 8'd1 : iBURST_LEN;
                end
            end
            ST_RUN: begin
                // Dropping iENA ends the run in this cycle: no hits, no frame start.
                stop     = (mode_q == MODE_PERIODIC) && !iENA;
                run      = !stop;
                sample_d = {TAG, cnt_q};
                if (run && cnt_q == '0) begin
                    frame_d = frame_q + 16'd1;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    cnt_d    = '0;
                    period_d = eff_period(iPERIOD);
                    if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_IDLE;
                    end else if (mode_q == MODE_BURST) begin
                        if (burst_q == 8'd1) begin
                            state_d = ST_IDLE;
                        end else begin
                            burst_d = burst_q - 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        active_d = (state_d == ST_RUN);
    end

    always_ff @(posedge iCLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_PERIODIC;
            period_q <= '0;
            cnt_q    <= '0;
            burst_q  <= '0;
            frame_q  <= '0;
            sample_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            burst_q  <= burst_d;
            frame_q  <= frame_d;
            sample_q <= sample_d;
            active_q <= active_d;
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        blvds_ch_strobe #(
            .CNT_W  (CNT_W),
            .OFFSET (k * STAGGER)
        ) u_ch (
            .clk_i     (iCLK),
            .rst_ni    (rst_n_sync),
            .run_i     (run),
            .cnt_i     (cnt_q),
            .mask_i    (iCH_MASK[k]),
            .busy_i    (iBUSY[k]),
            .clr_ovr_i (iCLR_OVR),
            .init_o    (oINIT[k]),
            .overrun_o (oOVERRUN[k])
        );
    end

    assign oSAMPLE    = sample_q;
    assign oFRAME_CNT = frame_q;
    assign oACTIVE    = active_q;
    assign oDBG_STATE = state_q;

endmodule
